// File: rtl/alu_issue_seq_if.sv
// alu_issue_seq_if: instruction handshake, ALU operand/result bus and writeback port bundle.
// master = sequencer side, slave = instruction source / ALU / writeback observer side.
interface alu_issue_seq_if;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [4:0]  alu_instruction;
    logic [31:0] alu_num1;
    logic [31:0] alu_num2;
    logic [31:0] alu_result;
    logic [3:0]  alu_flags;
    logic        wb_valid;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    modport master (
        input  instr_valid, instr, alu_result, alu_flags,
        output instr_ready, alu_instruction, alu_num1, alu_num2, wb_valid, wb_rd, wb_data
    );
    modport slave (
        output instr_valid, instr, alu_result, alu_flags,
        input  instr_ready, alu_instruction, alu_num1, alu_num2, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/alu_issue_seq.sv
// alu_issue_seq: decodes 16-bit reg-reg instructions, issues one ALU op each, waits out its latency, writes back.
// Optional macro ALU_SEQ_IMM_EN: instr[0]=1 replaces operand 2 with the immediate instr[4:1].
module alu_issue_seq #(
    parameter int ALU_LATENCY = 1,
    parameter int NREGS = 8
) (
    input  logic        clk,
    input  logic        rst,
    alu_issue_seq_if.master bus,
    input  logic        ld_en,
    input  logic [2:0]  ld_addr,
    input  logic [31:0] ld_data,
    output logic [3:0]  flags_q,
    output logic        illegal,
    output logic        busy,
    input  logic [2:0]  dbg_addr,
    output logic [31:0] dbg_data
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, WB} state_t;
    localparam logic [4:0] OP_CMP = 5'd18;
    localparam logic [1:0] WAIT_LAST = 2'(ALU_LATENCY - 2);
    state_t state_q, state_d;
    logic [15:0] ir_q, ir_d;
    logic [1:0] cnt_q, cnt_d;
    logic illegal_q, illegal_d;
    logic [3:0] flags_d;
    logic [31:0] num1_q, num1_d, num2_q, num2_d, opb;
    logic [31:0] regs_q [NREGS];
    logic [31:0] regs_d [NREGS];
    logic [4:0] op, new_op;
    logic [2:0] rd, rn, rm;
    logic new_legal;
    assign {op, rd, rn, rm} = ir_q[15:2];
    assign new_op = bus.instr[15:11];
    assign new_legal = new_op != 5'd0 && new_op <= OP_CMP;
`ifdef ALU_SEQ_IMM_EN
    assign opb = ir_q[0] ? {28'b0, ir_q[4:1]} : regs_q[rm];
`else
    logic unused_lo;
    assign unused_lo = ^ir_q[1:0];
    assign opb = regs_q[rm];
`endif
    assign bus.instr_ready = state_q == IDLE;
    assign busy = state_q != IDLE;
    assign illegal = illegal_q;
    assign bus.alu_num1 = num1_d;
    assign bus.alu_num2 = num2_d;
    assign dbg_data = regs_q[dbg_addr];
    always_comb begin
        state_d = state_q;
        ir_d = ir_q;
        cnt_d = cnt_q;
        illegal_d = 1'b0;
        flags_d = flags_q;
        num1_d = num1_q;
        num2_d = num2_q;
        regs_d = regs_q;
        bus.alu_instruction = '0;
        bus.wb_valid = 1'b0;
        bus.wb_rd = '0;
        bus.wb_data = '0;
        case (state_q)
            IDLE: begin
                // preload lands at the accept edge, so ISSUE already reads the new value
                if (ld_en) regs_d[ld_addr] = ld_data;
                if (bus.instr_valid) begin
                    ir_d = bus.instr;
                    illegal_d = !new_legal;
                    state_d = new_legal ? ISSUE : IDLE;
                end
            end
            ISSUE: begin
                bus.alu_instruction = op;
                num1_d = regs_q[rn];
                num2_d = opb;
                cnt_d = '0;
                state_d = ALU_LATENCY == 1 ? WB : WAIT;
            end
            WAIT: begin
                cnt_d = cnt_q + 2'd1;
                state_d = cnt_q == WAIT_LAST ? WB : WAIT;
            end
            WB: begin
                flags_d = bus.alu_flags;
                if (op != OP_CMP) begin
                    bus.wb_valid = 1'b1;
                    bus.wb_rd = rd;
                    bus.wb_data = bus.alu_result;
                    regs_d[rd] = bus.alu_result;
                end
                state_d = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ir_q <= '0;
            cnt_q <= '0;
            illegal_q <= 1'b0;
            flags_q <= '0;
            num1_q <= '0;
            num2_q <= '0;
            regs_q <= '{default: '0};
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            cnt_q <= cnt_d;
            illegal_q <= illegal_d;
            flags_q <= flags_d;
            num1_q <= num1_d;
            num2_q <= num2_d;
            regs_q <= regs_d;
        end
    end
endmodule
